// File: rtl/dff_response_monitor_if.sv
// Signal bundle between a D flip-flop under observation and its response monitor.
// The master side drives D/Q/Qbar/CLR; the slave side (the monitor) returns status.
interface dff_response_monitor_if #(
  parameter int CNT_W = 16
);
  logic             D;
  logic             Q;
  logic             Qbar;
  logic             CLR;
  logic             err;
  logic             forced;
  logic             fail;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] comp_cnt;
  logic [CNT_W-1:0] first_err_cyc;
  logic [CNT_W-1:0] cyc_cnt;

  modport master (
    output D, Q, Qbar, CLR,
    input  err, forced, fail, err_cnt, comp_cnt, first_err_cyc, cyc_cnt
  );

  modport slave (
    input  D, Q, Qbar, CLR,
    output err, forced, fail, err_cnt, comp_cnt, first_err_cyc, cyc_cnt
  );
endinterface

// File: rtl/dff_response_monitor.sv
// Response-side checker for an edge-triggered D flip-flop: reference model of Q,
// mismatch/complement counters and a run-length FSM that flags forced/stuck outputs.
module dff_response_monitor #(
  parameter int CNT_W  = 16,
  parameter int RUN_TH = 3
) (
  input logic                  CLK,
  input logic                  RESET,
  dff_response_monitor_if.slave mon
);
  localparam int RUN_W = $clog2(RUN_TH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_TH);

  typedef enum logic [1:0] {IDLE, ARMED, MISMATCH, FORCED} state_t;

  state_t           state_reg;
  logic             exp_reg;
  logic             vld_reg;
  logic [RUN_W-1:0] run_reg;
  logic             first_seen_reg;
  logic             err_reg;
  logic             forced_reg;
  logic             fail_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic [CNT_W-1:0] comp_cnt_reg;
  logic [CNT_W-1:0] first_err_cyc_reg;
  logic [CNT_W-1:0] cyc_cnt_reg;

  logic             mismatch;
  logic             comp_err;
  logic [RUN_W-1:0] run_inc;
  logic [CNT_W-1:0] cyc_cnt_next;

  // Q seen before the edge is compared with the D captured one edge earlier.
  assign mismatch     = vld_reg && (mon.Q != exp_reg);
  assign comp_err     = vld_reg && (mon.Qbar == mon.Q);
  assign run_inc      = (run_reg == RUN_MAX) ? RUN_MAX : run_reg + 1'b1;
  assign cyc_cnt_next = cyc_cnt_reg + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg         <= IDLE;
      exp_reg           <= 1'b0;
      vld_reg           <= 1'b0;
      run_reg           <= '0;
      first_seen_reg    <= 1'b0;
      err_reg           <= 1'b0;
      forced_reg        <= 1'b0;
      fail_reg          <= 1'b0;
      err_cnt_reg       <= '0;
      comp_cnt_reg      <= '0;
      first_err_cyc_reg <= '0;
      cyc_cnt_reg       <= '0;
    end else begin
      exp_reg     <= mon.D;
      vld_reg     <= 1'b1;
      cyc_cnt_reg <= cyc_cnt_next;

      case (state_reg)
        IDLE: begin
          state_reg  <= ARMED;
          forced_reg <= 1'b0;
        end
        default: begin
          if (mon.CLR) begin
            state_reg  <= ARMED;
            forced_reg <= 1'b0;
          end else if (mismatch) begin
            state_reg  <= (run_inc == RUN_MAX) ? FORCED : MISMATCH;
            forced_reg <= (run_inc == RUN_MAX);
          end else begin
            state_reg  <= ARMED;
            forced_reg <= 1'b0;
          end
        end
      endcase

      // CLR takes priority over any sample on the same edge.
      if (mon.CLR) begin
        run_reg           <= '0;
        err_reg           <= 1'b0;
        fail_reg          <= 1'b0;
        err_cnt_reg       <= '0;
        comp_cnt_reg      <= '0;
        first_err_cyc_reg <= '0;
        first_seen_reg    <= 1'b0;
      end else begin
        run_reg <= mismatch ? run_inc : '0;
        err_reg <= mismatch;
        if (mismatch && (err_cnt_reg != '1))
          err_cnt_reg <= err_cnt_reg + 1'b1;
        if (comp_err && (comp_cnt_reg != '1))
          comp_cnt_reg <= comp_cnt_reg + 1'b1;
        if (mismatch && !first_seen_reg) begin
          first_err_cyc_reg <= cyc_cnt_next;
          first_seen_reg    <= 1'b1;
        end
        if (mismatch || comp_err)
          fail_reg <= 1'b1;
      end
    end
  end

  assign mon.err           = err_reg;
  assign mon.forced        = forced_reg;
  assign mon.fail          = fail_reg;
  assign mon.err_cnt       = err_cnt_reg;
  assign mon.comp_cnt      = comp_cnt_reg;
  assign mon.first_err_cyc = first_err_cyc_reg;
  assign mon.cyc_cnt       = cyc_cnt_reg;
endmodule

// File: tb/tb_dff_response_monitor.sv
// Directed bench: a behavioural flip-flop with override knobs feeds the monitor;
// a second narrow-counter instance exercises saturation and CLR.
module tb_dff_response_monitor;
  logic CLK = 1'b0;
  logic RESET;
  logic d, force_en, force_val, glitch, comp_fault;
  logic sat_stuck, sat_clr;
  logic dff_q, q_drv;
  int   checks = 0;
  int   errors = 0;

  dff_response_monitor_if #(.CNT_W(16)) m_if ();
  dff_response_monitor_if #(.CNT_W(4))  s_if ();

  dff_response_monitor #(.CNT_W(16), .RUN_TH(3)) dut (
    .CLK(CLK), .RESET(RESET), .mon(m_if)
  );
  dff_response_monitor #(.CNT_W(4), .RUN_TH(3)) dut_sat (
    .CLK(CLK), .RESET(RESET), .mon(s_if)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) dff_q <= 1'b0;
    else       dff_q <= d;
  end

  assign q_drv     = force_en ? force_val : (glitch ? ~dff_q : dff_q);
  assign m_if.D    = d;
  assign m_if.Q    = q_drv;
  assign m_if.Qbar = comp_fault ? q_drv : ~q_drv;
  assign m_if.CLR  = 1'b0;
  assign s_if.D    = 1'b0;
  assign s_if.Q    = sat_stuck;
  assign s_if.Qbar = ~sat_stuck;
  assign s_if.CLR  = sat_clr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_err"},      32'(m_if.err), 0);
    check({tag, "_forced"},   32'(m_if.forced), 0);
    check({tag, "_fail"},     32'(m_if.fail), 0);
    check({tag, "_err_cnt"},  32'(m_if.err_cnt), 0);
    check({tag, "_comp_cnt"}, 32'(m_if.comp_cnt), 0);
    check({tag, "_first"},    32'(m_if.first_err_cyc), 0);
    check({tag, "_cyc"},      32'(m_if.cyc_cnt), 0);
    check({tag, "_s_err_cnt"}, 32'(s_if.err_cnt), 0);
    check({tag, "_s_cyc"},     32'(s_if.cyc_cnt), 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_zero(tag);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; d = 1'b0; force_en = 1'b0; force_val = 1'b0;
    glitch = 1'b0; comp_fault = 1'b0; sat_stuck = 1'b0; sat_clr = 1'b0;
    #1;
    check_zero("por");
    @(negedge CLK);
    RESET = 1'b0;

    // Clean run: D toggles every 20 units.
    for (int k = 1; k <= 29; k++) begin
      step();
      check("clean_err", 32'(m_if.err), 0);
      check("clean_forced", 32'(m_if.forced), 0);
      if (k % 2 == 0) d = ~d;
    end
    check("clean_err_cnt", 32'(m_if.err_cnt), 0);
    check("clean_comp_cnt", 32'(m_if.comp_cnt), 0);
    check("clean_fail", 32'(m_if.fail), 0);
    check("clean_cyc", 32'(m_if.cyc_cnt), 29);

    // Force window: Q held at 1 for samples 5..9 with D = 0.
    do_reset("rst_force");
    d = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("force_err_%0d", k), 32'(m_if.err), (k >= 5 && k <= 9) ? 1 : 0);
      check($sformatf("force_forced_%0d", k), 32'(m_if.forced), (k >= 7 && k <= 9) ? 1 : 0);
      if (k == 4) begin force_en = 1'b1; force_val = 1'b1; end
      if (k == 9) force_en = 1'b0;
    end
    check("force_err_cnt", 32'(m_if.err_cnt), 5);
    check("force_first", 32'(m_if.first_err_cyc), 5);
    check("force_fail", 32'(m_if.fail), 1);
    check("force_comp_cnt", 32'(m_if.comp_cnt), 0);

    // Single glitch on sample 8 with toggling data.
    do_reset("rst_glitch");
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("glitch_err_%0d", k), 32'(m_if.err), (k == 8) ? 1 : 0);
      check("glitch_forced", 32'(m_if.forced), 0);
      d = 1'(k % 2);
      glitch = (k == 7);
    end
    check("glitch_err_cnt", 32'(m_if.err_cnt), 1);
    check("glitch_first", 32'(m_if.first_err_cyc), 8);
    check("glitch_comp_cnt", 32'(m_if.comp_cnt), 0);
    check("glitch_fail", 32'(m_if.fail), 1);

    // Complement fault: Qbar = Q for samples 4..7.
    do_reset("rst_comp");
    for (int k = 1; k <= 9; k++) begin
      step();
      check("comp_err", 32'(m_if.err), 0);
      if (k == 5) check("comp_cnt_mid", 32'(m_if.comp_cnt), 2);
      d = 1'(k % 2);
      comp_fault = (k >= 3 && k <= 6);
    end
    check("comp_cnt", 32'(m_if.comp_cnt), 4);
    check("comp_err_cnt", 32'(m_if.err_cnt), 0);
    check("comp_fail", 32'(m_if.fail), 1);
    check("comp_forced", 32'(m_if.forced), 0);

    // Saturation on the 4-bit instance, then CLR coinciding with a mismatch.
    do_reset("rst_sat");
    d = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      step();
      if (k == 16) check("sat_cnt_16", 32'(s_if.err_cnt), 15);
      if (k == 20) check("sat_cnt_20", 32'(s_if.err_cnt), 15);
      if (k == 21) begin
        check("sat_cnt_21", 32'(s_if.err_cnt), 15);
        check("sat_fail", 32'(s_if.fail), 1);
        check("sat_forced", 32'(s_if.forced), 1);
        check("sat_first", 32'(s_if.first_err_cyc), 2);
        check("sat_cyc_21", 32'(s_if.cyc_cnt), 5);
      end
      if (k == 22) begin
        check("clr_err_cnt", 32'(s_if.err_cnt), 0);
        check("clr_fail", 32'(s_if.fail), 0);
        check("clr_err", 32'(s_if.err), 0);
        check("clr_forced", 32'(s_if.forced), 0);
        check("clr_first", 32'(s_if.first_err_cyc), 0);
        check("clr_cyc", 32'(s_if.cyc_cnt), 6);
      end
      if (k == 23) begin
        check("post_clr_err_cnt", 32'(s_if.err_cnt), 0);
        check("post_clr_err", 32'(s_if.err), 0);
        check("post_clr_cyc", 32'(s_if.cyc_cnt), 7);
      end
      sat_stuck = (k >= 1 && k <= 21);
      sat_clr   = (k == 21);
    end

    // Reset while FORCED, then confirm monitoring restarts.
    do_reset("rst_pre6");
    d = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin force_en = 1'b1; force_val = 1'b1; end
    end
    check("pre_rst_forced", 32'(m_if.forced), 1);
    check("pre_rst_err", 32'(m_if.err), 1);
    do_reset("rst_mid_forced");
    force_en = 1'b0;
    step();
    check("restart_err_1", 32'(m_if.err), 0);
    check("restart_forced_1", 32'(m_if.forced), 0);
    check("restart_cyc_1", 32'(m_if.cyc_cnt), 1);
    step();
    check("restart_err_2", 32'(m_if.err), 0);
    check("restart_cyc_2", 32'(m_if.cyc_cnt), 2);
    force_en = 1'b1;
    step();
    force_en = 1'b0;
    check("restart_err_3", 32'(m_if.err), 1);
    check("restart_err_cnt", 32'(m_if.err_cnt), 1);
    check("restart_first", 32'(m_if.first_err_cyc), 3);
    check("restart_forced_3", 32'(m_if.forced), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
